// File: rtl/alu_seq_ctrl_if.sv
// Instruction and result handshake bundle for alu_seq_ctrl.
// master = instruction source / result sink, slave = the controller.
interface alu_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [2:0]  res_flags;

  modport master (
    output in_valid, in_instr, res_ready,
    input  in_ready, res_valid, res_data, res_flags
  );

  modport slave (
    input  in_valid, in_instr, res_ready,
    output in_ready, res_valid, res_data, res_flags
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Issue-side controller for the 8-bit combinational ALU with a 4 x 8 register file.
// Optional immediate operand enabled by defining ALU_SEQ_IMM_EN.
module alu_seq_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  alu_seq_ctrl_if.slave        bus,
  input  logic                 rf_we,
  input  logic [1:0]           rf_waddr,
  input  logic [7:0]           rf_wdata,
  output logic [7:0]           alu_rx,
  output logic [7:0]           alu_ry,
  output logic [2:0]           alu_sel,
  input  logic [7:0]           alu_r0,
  input  logic [2:0]           alu_ban,
  output logic [2:0]           status,
  input  logic [1:0]           dbg_sel,
  output logic [7:0]           dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  rf [4];
  logic [1:0]  rd_q;
  logic        res_valid_q;
  logic [7:0]  res_data_q;
  logic [2:0]  res_flags_q;
  logic        ready;
  logic        accept;
  logic [7:0]  ry_next;

  logic [2:0]  f_op;
  logic [1:0]  f_rd;
  logic [1:0]  f_rs1;
  logic [1:0]  f_rs2;

  assign f_op  = bus.in_instr[15:13];
  assign f_rd  = bus.in_instr[12:11];
  assign f_rs1 = bus.in_instr[10:9];
  assign f_rs2 = bus.in_instr[1:0];

`ifdef ALU_SEQ_IMM_EN
  assign ry_next = bus.in_instr[8] ? bus.in_instr[7:0] : rf[f_rs2];
`else
  logic unused_imm;
  assign unused_imm = ^bus.in_instr[8:2];
  assign ry_next    = rf[f_rs2];
`endif

  assign ready  = (state == IDLE) && !rf_we;
  assign accept = ready && bus.in_valid;

  assign bus.in_ready  = ready;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;
  assign dbg_data      = rf[dbg_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are latched at acceptance, so write-back in ISSUE cannot disturb them even when rd aliases a source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) rf[i] <= '0;
      alu_rx      <= '0;
      alu_ry      <= '0;
      alu_sel     <= '0;
      rd_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      status      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
          end else if (accept) begin
            alu_sel <= f_op;
            alu_rx  <= rf[f_rs1];
            alu_ry  <= ry_next;
            rd_q    <= f_rd;
          end
        end
        ISSUE: begin
          rf[rd_q]    <= alu_r0;
          status      <= alu_ban;
          res_flags_q <= alu_ban;
          res_data_q  <= alu_r0;
          res_valid_q <= 1'b1;
        end
        RESP: begin
          if (bus.res_ready) res_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: attached ALU model, directed cases and random instructions
// checked against a register-file reference model.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_ctrl_if bus ();

  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] alu_rx, alu_ry, alu_r0;
  logic [2:0] alu_sel, alu_ban, status;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  alu_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .alu_rx   (alu_rx),
    .alu_ry   (alu_ry),
    .alu_sel  (alu_sel),
    .alu_r0   (alu_r0),
    .alu_ban  (alu_ban),
    .status   (status),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // ALU behaviour: returns {bit7, carry, zero, result}
  function automatic logic [10:0] alu_fn(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] w;
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    w = '0;
    case (op)
      3'd0: begin w = {1'b0, x} + {1'b0, y}; r = w[7:0]; c = w[8]; end
      3'd1: begin w = {1'b0, x} - {1'b0, y}; r = w[7:0]; c = w[8]; end
      3'd2: r = x | y;
      3'd3: r = x ^ y;
      3'd4: r = y;
      3'd5: r = x & y;
      3'd6: begin r = {x[6:0], 1'b0}; c = x[7]; end
      default: begin r = {1'b0, x[7:1]}; c = x[0]; end
    endcase
    return {r[7], c, (r == 8'h00), r};
  endfunction

  always_comb {alu_ban, alu_r0} = alu_fn(alu_sel, alu_rx, alu_ry);

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] mrf [4];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [1:0] a, input logic [7:0] d, input logic with_valid);
    rf_we        = 1'b1;
    rf_waddr     = a;
    rf_wdata     = d;
    bus.in_valid = with_valid;
    bus.in_instr = 16'(($urandom));
    #1;
    chk("preload_in_ready", {15'd0, bus.in_ready}, 16'd0);
    step();
    rf_we        = 1'b0;
    bus.in_valid = 1'b0;
    mrf[a]       = d;
    dbg_sel      = a;
    #1;
    chk("preload_dbg", {8'd0, dbg_data}, {8'd0, d});
    chk("preload_no_accept", {15'd0, bus.in_ready}, 16'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic imm, input logic [7:0] imm8, input int hold);
    logic [7:0] ex_x, ex_y, er;
    logic [2:0] ef;
    for (int i = 0; i < 20 && !bus.in_ready; i++) step();
    chk("in_ready_wait", {15'd0, bus.in_ready}, 16'd1);
    ex_x = mrf[rs1];
`ifdef ALU_SEQ_IMM_EN
    ex_y = imm ? imm8 : mrf[imm8[1:0]];
`else
    ex_y = mrf[imm8[1:0]];
`endif
    bus.in_valid = 1'b1;
    bus.in_instr = {op, rd, rs1, imm, imm8};
    step();
    bus.in_valid = 1'b0;
    bus.in_instr = 16'(($urandom));
    chk("alu_rx", {8'd0, alu_rx}, {8'd0, ex_x});
    chk("alu_ry", {8'd0, alu_ry}, {8'd0, ex_y});
    chk("alu_sel", {13'd0, alu_sel}, {13'd0, op});
    chk("issue_res_valid", {15'd0, bus.res_valid}, 16'd0);
    chk("issue_in_ready", {15'd0, bus.in_ready}, 16'd0);
    {ef, er} = alu_fn(op, ex_x, ex_y);
    step();
    chk("res_valid", {15'd0, bus.res_valid}, 16'd1);
    chk("res_data", {8'd0, bus.res_data}, {8'd0, er});
    chk("res_flags", {13'd0, bus.res_flags}, {13'd0, ef});
    chk("status", {13'd0, status}, {13'd0, ef});
    mrf[rd] = er;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", {15'd0, bus.res_valid}, 16'd1);
      chk("hold_data", {5'd0, bus.res_flags, bus.res_data}, {5'd0, ef, er});
      chk("hold_in_ready", {15'd0, bus.in_ready}, 16'd0);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("done_res_valid", {15'd0, bus.res_valid}, 16'd0);
    chk("done_in_ready", {15'd0, bus.in_ready}, 16'd1);
    chk("alu_rx_hold", {8'd0, alu_rx}, {8'd0, ex_x});
    dbg_sel = rd;
    #1;
    chk("writeback", {8'd0, dbg_data}, {8'd0, er});
  endtask

  initial begin
    rst           = 1'b1;
    rf_we         = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    dbg_sel       = '0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) mrf[i] = '0;
    step();
    step();
    rst = 1'b0;
    step();

    chk("rst_outputs", {alu_rx, alu_ry}, 16'h0000);
    chk("rst_sel_status", {10'd0, alu_sel, status}, 16'd0);
    chk("rst_res", {4'd0, bus.res_valid, bus.res_flags, bus.res_data}, 16'd0);
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk("rst_dbg", {8'd0, dbg_data}, 16'd0);
    end

    // ADD 0x7F + 0x01; second preload also offers an instruction that must lose
    preload(2'd1, 8'h7F, 1'b0);
    preload(2'd2, 8'h01, 1'b1);
    issue(3'd0, 2'd3, 2'd1, 1'b0, 8'h02, 0);
    chk("add_status", {13'd0, status}, 16'b100);
    dbg_sel = 2'd3;
    #1;
    chk("add_r3", {8'd0, dbg_data}, 16'h0080);

    // SUB to zero
    preload(2'd1, 8'h55, 1'b0);
    preload(2'd2, 8'h55, 1'b0);
    issue(3'd1, 2'd0, 2'd1, 1'b0, 8'h02, 0);
    chk("sub_zero_flag", {15'd0, status[0]}, 16'd1);
    dbg_sel = 2'd0;
    #1;
    chk("sub_r0", {8'd0, dbg_data}, 16'h0000);

    // Backpressure, rd aliasing rs1
    issue(3'd2, 2'd1, 2'd1, 1'b0, 8'h03, 5);

    // Immediate AND
    preload(2'd1, 8'hF0, 1'b0);
    preload(2'd0, 8'h66, 1'b0);
    issue(3'd5, 2'd2, 2'd1, 1'b1, 8'h3C, 0);
    dbg_sel = 2'd2;
    #1;
`ifdef ALU_SEQ_IMM_EN
    chk("imm_and", {8'd0, dbg_data}, 16'h0030);
`else
    chk("imm_and", {8'd0, dbg_data}, 16'h0060);
`endif

    // Reset during ISSUE
    preload(2'd3, 8'hAA, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_instr = {3'd0, 2'd3, 2'd3, 1'b0, 8'h03};
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_res_valid", {15'd0, bus.res_valid}, 16'd0);
    dbg_sel = 2'd3;
    #1;
    chk("midrst_r3", {8'd0, dbg_data}, 16'd0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("midrst_no_wb", {8'd0, dbg_data}, 16'd0);
    chk("midrst_idle", {14'd0, bus.in_ready, bus.res_valid}, 16'b10);
    for (int i = 0; i < 4; i++) mrf[i] = '0;

    // Random instructions with occasional preloads
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        preload(2'($urandom), 8'($urandom), 1'($urandom));
      issue(3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
            int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
